// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel switch logic: debounce FSM states
// and counter widths used by every switch channel.
package panel_pkg;

  localparam int DEB_CNT_W = 16;
  localparam int REP_CNT_W = 24;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } deb_state_t;

endpackage

// File: rtl/switch_debounce_if.sv
// Switch bundle between the raw front-panel levels and the debouncer outputs.
// master: the side that drives the raw switch levels and consumes the results.
// slave:  the debouncer itself.
interface switch_debounce_if #(
  parameter int NUM_SW = 8
);

  logic [NUM_SW-1:0] sw_in;
  logic [NUM_SW-1:0] sw_state;
  logic [NUM_SW-1:0] press_out;
  logic [NUM_SW-1:0] rel_out;

  modport master (
    output sw_in,
    input  sw_state,
    input  press_out,
    input  rel_out
  );

  modport slave (
    input  sw_in,
    output sw_state,
    output press_out,
    output rel_out
  );

endinterface

// File: rtl/switch_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, debounce FSM with a saturating
// 16-bit stability counter, and registered level/press/release outputs.
// Optional feature macro: AUTO_REPEAT_EN adds a 24-bit hold counter that
// re-fires the press strobe while the switch stays held.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   LOW     | accepted level 0, input agrees
//   WAIT_HI | accepted level 0, input has been 1 for cnt samples
//   HIGH    | accepted level 1, input agrees
//   WAIT_LO | accepted level 1, input has been 0 for cnt samples
module switch_debounce_chan
  import panel_pkg::*;
#(
  parameter int DEB_CYCLES    = 1000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 2000000,
  parameter int REPEAT_PERIOD = 500000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic sw_state,
  output logic press,
  output logic rel
);

  localparam logic [DEB_CNT_W-1:0] DEB_LIM = DEB_CNT_W'(DEB_CYCLES);

  logic                 sync_a;
  logic                 sync_b;
  deb_state_t           state;
  logic [DEB_CNT_W-1:0] cnt;

`ifdef AUTO_REPEAT_EN
  localparam logic [REP_CNT_W-1:0] DELAY_LIM  = REP_CNT_W'(REPEAT_DELAY);
  localparam logic [REP_CNT_W-1:0] PERIOD_LIM = REP_CNT_W'(REPEAT_PERIOD);

  logic [REP_CNT_W-1:0] hold;
  logic                 rep_phase;
  logic [REP_CNT_W-1:0] hold_inc;
  logic [REP_CNT_W-1:0] hold_target;
  logic                 rel_now;

  // Hold counter restarts after every repeat; first interval is the delay,
  // later ones the period. A release acceptance takes priority over a repeat.
  assign hold_inc    = hold + 1'b1;
  assign hold_target = rep_phase ? PERIOD_LIM : DELAY_LIM;
  assign rel_now     = (state == WAIT_LO) && !sync_b && (cnt == DEB_LIM);
`endif

  // Synchronizer, debounce FSM and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      state     <= LOW;
      cnt       <= '0;
      sw_state  <= 1'b0;
      press     <= 1'b0;
      rel       <= 1'b0;
`ifdef AUTO_REPEAT_EN
      hold      <= '0;
      rep_phase <= 1'b0;
`endif
    end else begin
      sync_a <= sw_in;
      sync_b <= sync_a;
      press  <= 1'b0;
      rel    <= 1'b0;

      case (state)
        LOW: begin
          if (sync_b) begin
            state <= WAIT_HI;
            cnt   <= DEB_CNT_W'(1);
          end
        end
        WAIT_HI: begin
          if (!sync_b) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == DEB_LIM) begin
            state    <= HIGH;
            cnt      <= '0;
            sw_state <= 1'b1;
            press    <= 1'b1;
`ifdef AUTO_REPEAT_EN
            hold      <= '0;
            rep_phase <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!sync_b) begin
            state <= WAIT_LO;
            cnt   <= DEB_CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (sync_b) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == DEB_LIM) begin
            state    <= LOW;
            cnt      <= '0;
            sw_state <= 1'b0;
            rel      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase

`ifdef AUTO_REPEAT_EN
      if ((state == HIGH) || ((state == WAIT_LO) && !rel_now)) begin
        if (hold_inc == hold_target) begin
          press     <= 1'b1;
          hold      <= '0;
          rep_phase <= 1'b1;
        end else begin
          hold <= hold_inc;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Multi-channel front-panel switch debouncer with press/release strobes.
// Each switch gets an independent switch_debounce_chan instance.
// Optional feature macro: AUTO_REPEAT_EN (auto-repeat press strobes while held).
module switch_debounce
  import panel_pkg::*;
#(
  parameter int NUM_SW        = 8,
  parameter int DEB_CYCLES    = 1000,
  parameter int REPEAT_DELAY  = 2000000,
  parameter int REPEAT_PERIOD = 500000
) (
  input logic              clk,
  input logic              reset,
  switch_debounce_if.slave bus
);

  logic [NUM_SW-1:0] state_vec;
  logic [NUM_SW-1:0] press_vec;
  logic [NUM_SW-1:0] rel_vec;

  // Reject out-of-range configurations at elaboration.
  if ((NUM_SW < 1) || (NUM_SW > 32) ||
      (DEB_CYCLES < 1) || (DEB_CYCLES > 65535) ||
      (REPEAT_DELAY < 1) || (REPEAT_DELAY >= (1 << REP_CNT_W)) ||
      (REPEAT_PERIOD < 1) || (REPEAT_PERIOD >= (1 << REP_CNT_W))) begin : g_bad_params
    $error("switch_debounce: parameter out of range");
  end

  // One independent debounce channel per switch.
  for (genvar i = 0; i < NUM_SW; i++) begin : g_chan
    switch_debounce_chan #(
      .DEB_CYCLES   (DEB_CYCLES)
`ifdef AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .sw_in   (bus.sw_in[i]),
      .sw_state(state_vec[i]),
      .press   (press_vec[i]),
      .rel     (rel_vec[i])
    );
  end

  assign bus.sw_state  = state_vec;
  assign bus.press_out = press_vec;
  assign bus.rel_out   = rel_vec;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed switch sequences, a window-based
// reference model checked every cycle, and literal checkpoints.
module tb_switch_debounce;

  localparam int NUM_SW = 4;
  localparam int DEB    = 4;
  localparam int RD     = 20;
  localparam int RP     = 8;

`ifdef AUTO_REPEAT_EN
  localparam logic [3:0] REP_EXP = 4'b1000;
`else
  localparam logic [3:0] REP_EXP = 4'b0000;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  switch_debounce_if #(.NUM_SW(NUM_SW)) bus ();

  switch_debounce #(
    .NUM_SW       (NUM_SW),
    .DEB_CYCLES   (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    bus.sw_in = v;
  endtask

  // Reference model: a channel flips its accepted level when the last DEB+1
  // synchronized samples (input as seen 2 edges earlier) all differ from it.
  // Auto-repeat fires at RD, RD+RP, RD+2RP... edges after the accepted press.
  initial begin : model_cmp
    logic [NUM_SW-1:0] hist[$];
    logic [3:0] exp_state, exp_press, exp_rel;
    int n;
    int t_acc[NUM_SW];
    bit all_diff;
    int el;
    exp_state = '0;
    n = 0;
    for (int i = 0; i < NUM_SW; i++) t_acc[i] = 0;
    for (int i = 0; i < DEB + 3; i++) hist.push_back('0);
    forever begin
      @(posedge clk);
      n++;
      exp_press = '0;
      exp_rel   = '0;
      if (reset) begin
        foreach (hist[i]) hist[i] = '0;
        exp_state = '0;
      end else begin
        hist.push_back(bus.sw_in);
        void'(hist.pop_front());
        for (int c = 0; c < NUM_SW; c++) begin
          all_diff = 1'b1;
          for (int k = 0; k <= DEB; k++)
            if (hist[k][c] == exp_state[c]) all_diff = 1'b0;
          if (all_diff) begin
            exp_state[c] = ~exp_state[c];
            if (exp_state[c]) begin
              exp_press[c] = 1'b1;
              t_acc[c] = n;
            end else begin
              exp_rel[c] = 1'b1;
            end
          end
`ifdef AUTO_REPEAT_EN
          else if (exp_state[c]) begin
            el = n - t_acc[c];
            if (el >= RD && ((el - RD) % RP) == 0) exp_press[c] = 1'b1;
          end
`endif
        end
      end
      #1;
      check("model sw_state", bus.sw_state, exp_state);
      check("model press_out", bus.press_out, exp_press);
      check("model rel_out", bus.rel_out, exp_rel);
    end
  end

  initial begin : stim
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.sw_in = '0;
    step(3);
    check("reset sw_state", bus.sw_state, 4'b0000);
    check("reset press_out", bus.press_out, 4'b0000);
    check("reset rel_out", bus.rel_out, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    step(3);

    // 1. clean press on channel 0
    drive(4'b0001);
    step(6);
    check("t1 no early press", bus.press_out, 4'b0000);
    step(1);
    check("t1 press", bus.press_out, 4'b0001);
    check("t1 state", bus.sw_state, 4'b0001);
    step(1);
    check("t1 press one cycle", bus.press_out, 4'b0000);

    // 2. bounce on channel 1
    drive(4'b0011); @(negedge clk);
    drive(4'b0001); @(negedge clk);
    drive(4'b0011); @(negedge clk);
    drive(4'b0001); @(negedge clk);
    drive(4'b0011);
    step(6);
    check("t2 no early press", bus.press_out, 4'b0000);
    step(1);
    check("t2 press", bus.press_out, 4'b0010);
    check("t2 state", bus.sw_state, 4'b0011);

    // 3. release channel 0
    drive(4'b0010);
    step(6);
    check("t3 no early rel", bus.rel_out, 4'b0000);
    step(1);
    check("t3 rel", bus.rel_out, 4'b0001);
    check("t3 state", bus.sw_state, 4'b0010);
    check("t3 no press", bus.press_out, 4'b0000);

    // 4. reset mid-debounce on channel 2
    drive(4'b0110);
    step(2);
    #1 reset = 1'b1;
    #1;
    check("t4 reset state", bus.sw_state, 4'b0000);
    check("t4 reset press", bus.press_out, 4'b0000);
    check("t4 reset rel", bus.rel_out, 4'b0000);
    step(2);
    @(negedge clk);
    reset = 1'b0;
    step(6);
    check("t4 no early press", bus.press_out, 4'b0000);
    step(1);
    check("t4 re-accept press", bus.press_out, 4'b0110);

    // 5. simultaneous press
    drive(4'b0000);
    step(12);
    drive(4'b1111);
    step(7);
    check("t5 press all", bus.press_out, 4'b1111);
    check("t5 state all", bus.sw_state, 4'b1111);
    step(1);
    check("t5 press one cycle", bus.press_out, 4'b0000);

    // 6. hold channel 3 (auto-repeat when enabled)
    drive(4'b0000);
    step(12);
    drive(4'b1000);
    step(7);
    check("t6 press at t", bus.press_out, 4'b1000);
    step(19);
    check("t6 quiet t+19", bus.press_out, 4'b0000);
    step(1);
    check("t6 repeat t+20", bus.press_out, REP_EXP);
    step(8);
    check("t6 repeat t+28", bus.press_out, REP_EXP);
    step(8);
    check("t6 repeat t+36", bus.press_out, REP_EXP);
    drive(4'b0000);
    step(7);
    check("t6 rel", bus.rel_out, 4'b1000);
    step(1);
    check("t6 no press after rel", bus.press_out, 4'b0000);
    check("t6 state after rel", bus.sw_state, 4'b0000);
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
